calc_session_controller: RTL and testbench

- Consumes the decoded op_mode/calc_type from the switch-mapping stage and runs one calculation session.
- Session sequence: user confirms the mode, selects operand A, then optionally B or a scalar. The block then launches the compute unit with a single-cycle start and waits for completion.
- Sits between the mode decoder/button debouncers and the matrix compute dispatcher. Drives status to LEDs and the 7-segment display.

---
 rtl/matrix_op_selector_pkg.sv | 53 +++++
 rtl/calc_session_controller.sv | 192 +++++++++++++++++++
 tb/tb_calc_session_controller.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_op_selector_pkg.sv
// Shared types for the matrix operation selector: decoded mode and
// calculation type from the switch-mapping stage, plus the session
// controller's state and error encodings.
package matrix_op_selector_pkg;

    // Top-level operating mode chosen on the switches.
    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_SINGLE  = 3'd1,
        OP_DOUBLE  = 3'd2,
        OP_SCALAR  = 3'd3,
        OP_INPUT   = 3'd4,
        OP_GEN     = 3'd5,
        OP_DISPLAY = 3'd6
    } op_mode_t;

    // Calculation requested from the compute dispatcher.
    typedef enum logic [2:0] {
        CALC_TRANSPOSE   = 3'd0,
        CALC_ADD         = 3'd1,
        CALC_MUL         = 3'd2,
        CALC_SCALAR_MUL  = 3'd3,
        CALC_DETERMINANT = 3'd4,
        CALC_CONV        = 3'd5
    } calc_type_t;

    // Session controller states; IDLE is zero so reset shows a blank display.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SEL_A      = 3'd1,
        ST_SEL_B      = 3'd2,
        ST_SEL_SCALAR = 3'd3,
        ST_LAUNCH     = 3'd4,
        ST_WAIT       = 3'd5,
        ST_DONE       = 3'd6,
        ST_ERROR      = 3'd7
    } session_state_t;

    // Reason for the most recent entry into ERROR.
    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_BAD_MODE = 3'd1,
        ERR_BAD_ID   = 3'd2,
        ERR_CALC     = 3'd3,
        ERR_TIMEOUT  = 3'd4
    } err_code_t;

    // Only the three compute modes can start a calculation session.
    function automatic logic is_calc_mode(logic [2:0] m);
        return (m == OP_SINGLE) || (m == OP_DOUBLE) || (m == OP_SCALAR);
    endfunction

endpackage

// File: rtl/calc_session_controller.sv
// Calculation session controller: walks the user through mode confirm and
// operand selection, launches the compute unit with a one-cycle start and
// waits for completion, error or timeout.
//
// Handshake: there is no valid/ready pair here. confirm_pulse, cancel_pulse,
// calc_done and calc_error are single-cycle pulses sampled on the rising
// edge; a pulse is acted on only in a state that listens for it and is
// otherwise dropped. calc_start is a one-cycle pulse asserted in LAUNCH;
// the compute unit must capture the operand outputs on that cycle, and they
// stay stable until the session returns to IDLE.
module calc_session_controller
    import matrix_op_selector_pkg::*;
#(
    parameter int ID_W           = 3,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        op_mode,
    input  logic [2:0]        calc_type,
    input  logic              confirm_pulse,
    input  logic              cancel_pulse,
    input  logic [ID_W-1:0]   sel_id,
    input  logic              sel_id_valid,
    input  logic [DATA_W-1:0] scalar_in,
    input  logic              calc_done,
    input  logic              calc_error,
    output logic              calc_start,
    output logic [2:0]        calc_type_out,
    output logic [ID_W-1:0]   op_a_id,
    output logic [ID_W-1:0]   op_b_id,
    output logic [DATA_W-1:0] scalar_out,
    output logic              busy,
    output logic [2:0]        session_state,
    output logic [2:0]        err_code
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    session_state_t    state_q, state_d;
    err_code_t         err_q, err_d;
    op_mode_t          mode_q;
    calc_type_t        calc_type_q;
    logic [ID_W-1:0]   op_a_q, op_b_q;
    logic [DATA_W-1:0] scalar_q;
    logic [CNT_W-1:0]  cnt_q;

    // A cancel in a selection state wins over a same-cycle confirm.
    logic sel_confirm;
    assign sel_confirm = confirm_pulse && !cancel_pulse;

    // State and error-code register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Next-state and next-error selection.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (confirm_pulse) begin
                    if (is_calc_mode(op_mode)) begin
                        state_d = ST_SEL_A;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = ERR_BAD_MODE;
                    end
                end
            end
            ST_SEL_A: begin
                if (cancel_pulse) begin
                    state_d = ST_IDLE;
                end else if (confirm_pulse) begin
                    if (!sel_id_valid) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_BAD_ID;
                    end else begin
                        case (mode_q)
                            OP_SINGLE: state_d = ST_LAUNCH;
                            OP_DOUBLE: state_d = ST_SEL_B;
                            OP_SCALAR: state_d = ST_SEL_SCALAR;
                            default: begin
                                // Unreachable: IDLE only admits compute modes.
                                state_d = ST_ERROR;
                                err_d   = ERR_BAD_MODE;
                            end
                        endcase
                    end
                end
            end
            ST_SEL_B: begin
                if (cancel_pulse) begin
                    state_d = ST_IDLE;
                end else if (confirm_pulse) begin
                    if (sel_id_valid) begin
                        state_d = ST_LAUNCH;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = ERR_BAD_ID;
                    end
                end
            end
            ST_SEL_SCALAR: begin
                if (cancel_pulse) begin
                    state_d = ST_IDLE;
                end else if (confirm_pulse) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // The compute unit cannot be aborted, so buttons are ignored.
                if (calc_error) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_CALC;
                end else if (calc_done) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (confirm_pulse || cancel_pulse) begin
                    state_d = ST_IDLE;
                    err_d   = ERR_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                err_d   = ERR_NONE;
            end
        endcase
    end

    // Operand latches and the WAIT timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= OP_NONE;
            calc_type_q <= CALC_TRANSPOSE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            scalar_q    <= '0;
            cnt_q       <= '0;
        end else begin
            if (state_q == ST_IDLE && confirm_pulse) begin
                mode_q      <= op_mode_t'(op_mode);
                calc_type_q <= calc_type_t'(calc_type);
            end
            if (state_q == ST_SEL_A && sel_confirm && sel_id_valid) begin
                op_a_q <= sel_id;
            end
            if (state_q == ST_SEL_B && sel_confirm && sel_id_valid) begin
                op_b_q <= sel_id;
            end
            if (state_q == ST_SEL_SCALAR && sel_confirm) begin
                scalar_q <= scalar_in;
            end
            // Counter restarts at every launch and saturates rather than wraps.
            if (state_q == ST_LAUNCH) begin
                cnt_q <= '0;
            end else if (state_q == ST_WAIT && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Moore outputs decoded from the current state and latched registers.
    always_comb begin
        calc_start    = (state_q == ST_LAUNCH);
        busy          = (state_q != ST_IDLE);
        session_state = state_q;
        err_code      = err_q;
        calc_type_out = calc_type_q;
        op_a_id       = op_a_q;
        op_b_id       = op_b_q;
        scalar_out    = scalar_q;
    end

endmodule

// File: tb/tb_calc_session_controller.sv
// Directed bench for calc_session_controller with a short timeout.
module tb_calc_session_controller;

    localparam int ID_W   = 3;
    localparam int DATA_W = 32;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        op_mode = 3'd0;
    logic [2:0]        calc_type = 3'd0;
    logic              confirm_pulse = 1'b0;
    logic              cancel_pulse = 1'b0;
    logic [ID_W-1:0]   sel_id = '0;
    logic              sel_id_valid = 1'b0;
    logic [DATA_W-1:0] scalar_in = '0;
    logic              calc_done = 1'b0;
    logic              calc_error = 1'b0;
    logic              calc_start;
    logic [2:0]        calc_type_out;
    logic [ID_W-1:0]   op_a_id;
    logic [ID_W-1:0]   op_b_id;
    logic [DATA_W-1:0] scalar_out;
    logic              busy;
    logic [2:0]        session_state;
    logic [2:0]        err_code;

    calc_session_controller #(
        .ID_W(ID_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .op_mode(op_mode), .calc_type(calc_type),
        .confirm_pulse(confirm_pulse), .cancel_pulse(cancel_pulse),
        .sel_id(sel_id), .sel_id_valid(sel_id_valid), .scalar_in(scalar_in),
        .calc_done(calc_done), .calc_error(calc_error),
        .calc_start(calc_start), .calc_type_out(calc_type_out),
        .op_a_id(op_a_id), .op_b_id(op_b_id), .scalar_out(scalar_out),
        .busy(busy), .session_state(session_state), .err_code(err_code)
    );

    // Clock
    always #5 clk = ~clk;

    // Expected encodings, written out independently of the RTL package.
    localparam logic [2:0] S_IDLE = 3'd0, S_SEL_A = 3'd1, S_SEL_B = 3'd2,
                           S_SEL_SC = 3'd3, S_LAUNCH = 3'd4, S_WAIT = 3'd5,
                           S_DONE = 3'd6, S_ERROR = 3'd7;
    localparam logic [2:0] E_NONE = 3'd0, E_MODE = 3'd1, E_ID = 3'd2,
                           E_CALC = 3'd3, E_TMO = 3'd4;

    typedef struct {
        logic [2:0]  mode;
        logic [2:0]  ctype;
        logic        conf;
        logic        canc;
        logic [2:0]  id;
        logic        idv;
        logic [31:0] scal;
        logic        done;
        logic        err;
        logic [2:0]  e_state;
        logic        e_start;
        logic [2:0]  e_err;
        logic [2:0]  e_a;
        logic [2:0]  e_b;
        logic [2:0]  e_ctype;
        logic [31:0] e_scal;
    } vec_t;

    vec_t vec_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic v(input logic [2:0] mode, input logic [2:0] ctype,
                     input logic conf, input logic canc,
                     input logic [2:0] id, input logic idv, input logic [31:0] scal,
                     input logic done, input logic err,
                     input logic [2:0] e_state, input logic e_start, input logic [2:0] e_err,
                     input logic [2:0] e_a, input logic [2:0] e_b,
                     input logic [2:0] e_ctype, input logic [31:0] e_scal);
        vec_t r;
        r.mode = mode; r.ctype = ctype; r.conf = conf; r.canc = canc;
        r.id = id; r.idv = idv; r.scal = scal; r.done = done; r.err = err;
        r.e_state = e_state; r.e_start = e_start; r.e_err = e_err;
        r.e_a = e_a; r.e_b = e_b; r.e_ctype = e_ctype; r.e_scal = e_scal;
        vec_q.push_back(r);
    endtask

    // Driver: apply one cycle of inputs at the falling edge, sample 1 after rise.
    task automatic drive(input vec_t r);
        @(negedge clk);
        op_mode = r.mode; calc_type = r.ctype;
        confirm_pulse = r.conf; cancel_pulse = r.canc;
        sel_id = r.id; sel_id_valid = r.idv; scalar_in = r.scal;
        calc_done = r.done; calc_error = r.err;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input vec_t r);
        chk({tag, ".state"}, 32'(session_state), 32'(r.e_state));
        chk({tag, ".start"}, 32'(calc_start), 32'(r.e_start));
        chk({tag, ".busy"}, 32'(busy), 32'(r.e_state != S_IDLE));
        chk({tag, ".err"}, 32'(err_code), 32'(r.e_err));
        chk({tag, ".op_a"}, 32'(op_a_id), 32'(r.e_a));
        chk({tag, ".op_b"}, 32'(op_b_id), 32'(r.e_b));
        chk({tag, ".ctype"}, 32'(calc_type_out), 32'(r.e_ctype));
        chk({tag, ".scalar"}, scalar_out, r.e_scal);
    endtask

    task automatic step(input string tag,
                        input logic [2:0] mode, input logic [2:0] ctype,
                        input logic conf, input logic canc,
                        input logic [2:0] id, input logic idv, input logic [31:0] scal,
                        input logic done, input logic err,
                        input logic [2:0] e_state, input logic e_start, input logic [2:0] e_err,
                        input logic [2:0] e_a, input logic [2:0] e_b,
                        input logic [2:0] e_ctype, input logic [31:0] e_scal);
        vec_t r;
        r.mode = mode; r.ctype = ctype; r.conf = conf; r.canc = canc;
        r.id = id; r.idv = idv; r.scal = scal; r.done = done; r.err = err;
        r.e_state = e_state; r.e_start = e_start; r.e_err = e_err;
        r.e_a = e_a; r.e_b = e_b; r.e_ctype = e_ctype; r.e_scal = e_scal;
        drive(r);
        check_vec(tag, r);
    endtask

    initial begin
        // Reset block
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.state", 32'(session_state), 32'(S_IDLE));
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.start", 32'(calc_start), 32'd0);
        chk("reset.ctype", 32'(calc_type_out), 32'd0);
        chk("reset.err", 32'(err_code), 32'(E_NONE));
        chk("reset.scalar", scalar_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table: mode ct conf canc id idv scal done err | state start err a b ct scal
        // SINGLE transpose, A=2, done after 5 cycles in WAIT
        v(3'd1, 3'd0, 1, 0, 3'd0, 0, 0, 0, 0, S_SEL_A,  0, E_NONE, 3'd0, 3'd0, 3'd0, 0);
        v(3'd1, 3'd0, 1, 0, 3'd2, 1, 0, 0, 0, S_LAUNCH, 1, E_NONE, 3'd2, 3'd0, 3'd0, 0);
        for (int i = 0; i < 4; i++)
            v(3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, S_WAIT, 0, E_NONE, 3'd2, 3'd0, 3'd0, 0);
        v(3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 0, S_DONE,   0, E_NONE, 3'd2, 3'd0, 3'd0, 0);
        v(3'd0, 3'd0, 1, 0, 3'd0, 0, 0, 0, 0, S_IDLE,   0, E_NONE, 3'd2, 3'd0, 3'd0, 0);
        // DOUBLE mul, A=1, B=4, mode switches moved in SEL_A are ignored, calc_error
        v(3'd2, 3'd2, 1, 0, 3'd0, 0, 0, 0, 0, S_SEL_A,  0, E_NONE, 3'd2, 3'd0, 3'd2, 0);
        v(3'd7, 3'd5, 1, 0, 3'd1, 1, 0, 0, 0, S_SEL_B,  0, E_NONE, 3'd1, 3'd0, 3'd2, 0);
        v(3'd2, 3'd2, 1, 0, 3'd4, 1, 0, 0, 0, S_LAUNCH, 1, E_NONE, 3'd1, 3'd4, 3'd2, 0);
        v(3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, S_WAIT,   0, E_NONE, 3'd1, 3'd4, 3'd2, 0);
        v(3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 1, S_ERROR,  0, E_CALC, 3'd1, 3'd4, 3'd2, 0);
        v(3'd0, 3'd0, 1, 0, 3'd0, 0, 0, 0, 0, S_IDLE,   0, E_NONE, 3'd1, 3'd4, 3'd2, 0);
        // Bad mode 3'b111
        v(3'd7, 3'd1, 1, 0, 3'd0, 0, 0, 0, 0, S_ERROR,  0, E_MODE, 3'd1, 3'd4, 3'd1, 0);
        v(3'd0, 3'd0, 0, 1, 3'd0, 0, 0, 0, 0, S_IDLE,   0, E_NONE, 3'd1, 3'd4, 3'd1, 0);
        // Invalid id in SEL_B leaves op_b untouched
        v(3'd2, 3'd2, 1, 0, 3'd0, 0, 0, 0, 0, S_SEL_A,  0, E_NONE, 3'd1, 3'd4, 3'd2, 0);
        v(3'd2, 3'd2, 1, 0, 3'd5, 1, 0, 0, 0, S_SEL_B,  0, E_NONE, 3'd5, 3'd4, 3'd2, 0);
        v(3'd2, 3'd2, 1, 0, 3'd6, 0, 0, 0, 0, S_ERROR,  0, E_ID,   3'd5, 3'd4, 3'd2, 0);
        v(3'd0, 3'd0, 0, 1, 3'd0, 0, 0, 0, 0, S_IDLE,   0, E_NONE, 3'd5, 3'd4, 3'd2, 0);
        // Done in LAUNCH ignored, buttons ignored in WAIT, done+error -> ERR_CALC
        v(3'd1, 3'd0, 1, 0, 3'd0, 0, 0, 0, 0, S_SEL_A,  0, E_NONE, 3'd5, 3'd4, 3'd0, 0);
        v(3'd1, 3'd0, 1, 0, 3'd3, 1, 0, 0, 0, S_LAUNCH, 1, E_NONE, 3'd3, 3'd4, 3'd0, 0);
        v(3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 0, S_WAIT,   0, E_NONE, 3'd3, 3'd4, 3'd0, 0);
        v(3'd0, 3'd0, 1, 1, 3'd0, 0, 0, 0, 0, S_WAIT,   0, E_NONE, 3'd3, 3'd4, 3'd0, 0);
        v(3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 1, S_ERROR,  0, E_CALC, 3'd3, 3'd4, 3'd0, 0);
        v(3'd0, 3'd0, 1, 0, 3'd0, 0, 0, 0, 0, S_IDLE,   0, E_NONE, 3'd3, 3'd4, 3'd0, 0);

        foreach (vec_q[i]) begin
            drive(vec_q[i]);
            check_vec($sformatf("vec%0d", i), vec_q[i]);
        end

        // SCALAR mode, scalar 7, then timeout after 16 WAIT cycles
        step("sc.idle", 3'd3, 3'd3, 1, 0, 3'd0, 0, 0, 0, 0, S_SEL_A, 0, E_NONE, 3'd3, 3'd4, 3'd3, 0);
        step("sc.sela", 3'd3, 3'd3, 1, 0, 3'd3, 1, 0, 0, 0, S_SEL_SC, 0, E_NONE, 3'd3, 3'd4, 3'd3, 0);
        step("sc.scal", 3'd3, 3'd3, 1, 0, 3'd0, 0, 32'h0000_0007, 0, 0, S_LAUNCH, 1, E_NONE, 3'd3, 3'd4, 3'd3, 32'd7);
        for (int i = 0; i < TMO; i++)
            step($sformatf("tmo.wait%0d", i), 3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0,
                 S_WAIT, 0, E_NONE, 3'd3, 3'd4, 3'd3, 32'd7);
        step("tmo.expire", 3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, S_ERROR, 0, E_TMO, 3'd3, 3'd4, 3'd3, 32'd7);
        step("tmo.exit", 3'd0, 3'd0, 1, 0, 3'd0, 0, 0, 0, 0, S_IDLE, 0, E_NONE, 3'd3, 3'd4, 3'd3, 32'd7);

        // Confirm and cancel together in SEL_A: back to IDLE, no launch, A untouched
        step("cc.idle", 3'd1, 3'd0, 1, 0, 3'd0, 0, 0, 0, 0, S_SEL_A, 0, E_NONE, 3'd3, 3'd4, 3'd0, 32'd7);
        step("cc.both", 3'd1, 3'd0, 1, 1, 3'd2, 1, 0, 0, 0, S_IDLE, 0, E_NONE, 3'd3, 3'd4, 3'd0, 32'd7);
        step("cc.after", 3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, S_IDLE, 0, E_NONE, 3'd3, 3'd4, 3'd0, 32'd7);

        // Asynchronous reset in the middle of WAIT
        step("rw.idle", 3'd1, 3'd2, 1, 0, 3'd0, 0, 0, 0, 0, S_SEL_A, 0, E_NONE, 3'd3, 3'd4, 3'd2, 32'd7);
        step("rw.sela", 3'd1, 3'd2, 1, 0, 3'd6, 1, 0, 0, 0, S_LAUNCH, 1, E_NONE, 3'd6, 3'd4, 3'd2, 32'd7);
        step("rw.wait", 3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, S_WAIT, 0, E_NONE, 3'd6, 3'd4, 3'd2, 32'd7);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rw.state", 32'(session_state), 32'(S_IDLE));
        chk("rw.busy", 32'(busy), 32'd0);
        chk("rw.start", 32'(calc_start), 32'd0);
        chk("rw.ctype", 32'(calc_type_out), 32'd0);
        chk("rw.op_a", 32'(op_a_id), 32'd0);
        chk("rw.op_b", 32'(op_b_id), 32'd0);
        chk("rw.scalar", scalar_out, 32'd0);
        chk("rw.err", 32'(err_code), 32'(E_NONE));
        @(negedge clk);
        rst = 1'b0;
        step("rw.done", 3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 0, S_IDLE, 0, E_NONE, 3'd0, 3'd0, 3'd0, 0);
        step("rw.quiet", 3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, S_IDLE, 0, E_NONE, 3'd0, 3'd0, 3'd0, 0);

        // Report
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
